// File: rtl/gen_logic.sv
// rtl/gen_logic.sv - burst word generator with optional idle gap before each offer
// Emits a counting payload on a valid/ready handshake; the data counter persists across bursts.
module gen_logic #(
    parameter int DW    = 32,
    parameter int DELAY = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   burst_len,
    output logic          down_valid,
    output logic [DW-1:0] down_data,
    input  logic          down_ready,
    output logic          busy,
    output logic          done,
    output logic [15:0]   sent_cnt
);

    localparam int GW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((DELAY > 0) ? (DELAY - 1) : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state, state_nx;
    logic [15:0]   remaining, remaining_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic          valid_nx;
    logic [DW-1:0] data_nx;
    logic          done_nx;
    logic          busy_nx;
    logic [15:0]   sent_nx;
    logic          xfer;

    assign xfer = down_valid && down_ready;

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        gap_nx       = gap_cnt;
        valid_nx     = down_valid;
        data_nx      = down_data;
        done_nx      = 1'b0;
        sent_nx      = sent_cnt;

        case (state)
            S_IDLE: begin
                valid_nx = 1'b0;
                if (start) begin
                    sent_nx = 16'd0;
                    if (burst_len == 16'd0) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end else begin
                        remaining_nx = burst_len;
                        if (DELAY > 0) begin
                            state_nx = S_GAP;
                            gap_nx   = GAP_LOAD;
                        end else begin
                            state_nx = S_SEND;
                            valid_nx = 1'b1;
                        end
                    end
                end
            end

            S_GAP: begin
                // The gap counter is loaded with DELAY-1 so the offer lands after exactly DELAY idle cycles
                if (gap_cnt == '0) begin
                    state_nx = S_SEND;
                    valid_nx = 1'b1;
                end else begin
                    gap_nx = gap_cnt - GW'(1);
                end
            end

            S_SEND: begin
                if (xfer) begin
                    remaining_nx = remaining - 16'd1;
                    sent_nx      = sent_cnt + 16'd1;
                    data_nx      = down_data + DW'(1);
                    if (remaining == 16'd1) begin
                        state_nx = S_DONE;
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                    end else if (DELAY > 0) begin
                        state_nx = S_GAP;
                        gap_nx   = GAP_LOAD;
                        valid_nx = 1'b0;
                    end
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
                valid_nx = 1'b0;
            end

            default: begin
                state_nx = S_IDLE;
                valid_nx = 1'b0;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            remaining  <= 16'd0;
            gap_cnt    <= '0;
            down_valid <= 1'b0;
            down_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_cnt   <= 16'd0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            gap_cnt    <= gap_nx;
            down_valid <= valid_nx;
            down_data  <= data_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            sent_cnt   <= sent_nx;
        end
    end

endmodule
